// File: rtl/accelerator_pkg.sv
// Shared types and helpers for the arith_stage sequencing logic.
// Beat arithmetic lives here so the sequencer and mask logic agree on element sizing.
package accelerator_pkg;

  localparam int SEQ_MAX_BEATS = 4;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_READ  = 2'd1,
    SEQ_DRAIN = 2'd2
  } arith_seq_state_t;

  // vsew=3 has no 64-bit datapath behind it, so it behaves as 32-bit.
  function automatic logic [1:0] eff_vsew(input logic [1:0] vsew);
    return (vsew == 2'd3) ? 2'd2 : vsew;
  endfunction

  function automatic logic [4:0] elems_per_beat(input logic [1:0] vsew, input logic reduction);
    if (reduction) return 5'd4;
    return 5'd16 >> eff_vsew(vsew);
  endfunction

  function automatic logic [2:0] beats_for(input logic [4:0] vl, input logic [1:0] vsew,
                                           input logic reduction);
    logic [2:0] lg;
    logic [5:0] sum;
    logic [5:0] n;
    lg  = reduction ? 3'd2 : (3'd4 - {1'b0, eff_vsew(vsew)});
    sum = {1'b0, vl} + {1'b0, elems_per_beat(vsew, reduction)} - 6'd1;
    n   = sum >> lg;
    return (n > 6'(SEQ_MAX_BEATS)) ? 3'(SEQ_MAX_BEATS) : 3'(n);
  endfunction

endpackage

// File: rtl/arith_wr_mask.sv
// Byte-enable generator for one written beat of a vector arith op.
// Reductions only ever write element 0; other ops enable the live elements of the beat.
module arith_wr_mask
  import accelerator_pkg::*;
(
  input  logic [4:0]  vl_i,
  input  logic [1:0]  vsew_i,
  input  logic [1:0]  beat_i,
  input  logic        reduction_i,
  output logic [15:0] be_o
);

  logic [1:0] sew;
  logic [4:0] elems;
  logic [6:0] first;
  logic [6:0] remain;
  logic [6:0] count;
  logic [4:0] nBytes;

  always_comb begin
    sew    = eff_vsew(vsew_i);
    elems  = elems_per_beat(vsew_i, 1'b0);
    first  = 7'(beat_i) * 7'(elems);
    remain = 7'd0;
    count  = 7'd0;
    nBytes = 5'd0;
    be_o   = 16'h0000;
    if (reduction_i) begin
      case (sew)
        2'd0:    be_o = 16'h0001;
        2'd1:    be_o = 16'h0003;
        default: be_o = 16'h000F;
      endcase
    end else if ({2'b00, vl_i} > first) begin
      // Tail beat: only the elements below vl carry valid results.
      remain = {2'b00, vl_i} - first;
      count  = (remain > {2'b00, elems}) ? {2'b00, elems} : remain;
      nBytes = 5'(count << sew);
      be_o   = 16'((17'd1 << nBytes) - 17'd1);
    end
  end

endmodule

// File: rtl/arith_sequencer.sv
// Multi-beat controller for arith_stage: issues register-file reads, then writes
// each beat one cycle later when its data has passed through arith_stage.
module arith_sequencer
  import accelerator_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_vl,
  input  logic [1:0]  req_vsew,
  input  logic        req_reduction,
  input  logic [4:0]  req_vs1,
  input  logic [4:0]  req_vs2,
  input  logic [4:0]  req_vd,
  input  logic        flush,
  output logic        rf_rd_en,
  output logic [4:0]  rf_vs1_idx,
  output logic [4:0]  rf_vs2_idx,
  output logic [1:0]  cycle_count,
  output logic        rf_wr_en,
  output logic [4:0]  rf_vd_idx,
  output logic [15:0] rf_wr_be,
  output logic        busy,
  output logic        done
);

  arith_seq_state_t state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [2:0]  nBeats_q, nBeats_d;
  logic [4:0]  vl_q, vs1_q, vs2_q, vd_q;
  logic [1:0]  vsew_q;
  logic        red_q;
  logic        accept;
  logic [1:0]  wrBeat;
  logic        wrActive;
  logic        doneRaw;
  logic [15:0] beMask;

  assign accept = (state_q == SEQ_IDLE) && req_valid;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    nBeats_d = nBeats_q;
    case (state_q)
      SEQ_IDLE: begin
        if (req_valid) begin
          nBeats_d = beats_for(req_vl, req_vsew, req_reduction);
          beat_d   = 2'd0;
          state_d  = (nBeats_d == 3'd0) ? SEQ_DRAIN : SEQ_READ;
        end
      end
      SEQ_READ: begin
        if (flush) begin
          state_d  = SEQ_IDLE;
          beat_d   = 2'd0;
          nBeats_d = 3'd0;
        end else if ({1'b0, beat_q} == nBeats_q - 3'd1) begin
          state_d = SEQ_DRAIN;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      default: begin
        state_d  = SEQ_IDLE;
        beat_d   = 2'd0;
        nBeats_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SEQ_IDLE;
      beat_q   <= 2'd0;
      nBeats_q <= 3'd0;
      vl_q     <= 5'd0;
      vsew_q   <= 2'd0;
      red_q    <= 1'b0;
      vs1_q    <= 5'd0;
      vs2_q    <= 5'd0;
      vd_q     <= 5'd0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      nBeats_q <= nBeats_d;
      if (accept) begin
        vl_q   <= req_vl;
        vsew_q <= req_vsew;
        red_q  <= req_reduction;
        vs1_q  <= req_vs1;
        vs2_q  <= req_vs2;
        vd_q   <= req_vd;
      end
    end
  end

  // Writes trail reads by one beat: in READ the data at arith_stage is beat_q-1.
  always_comb begin
    req_ready   = (state_q == SEQ_IDLE);
    busy        = (state_q != SEQ_IDLE);
    rf_rd_en    = 1'b0;
    rf_vs1_idx  = 5'd0;
    rf_vs2_idx  = 5'd0;
    cycle_count = 2'd0;
    wrBeat      = beat_q;
    wrActive    = 1'b0;
    doneRaw     = 1'b0;
    case (state_q)
      SEQ_READ: begin
        rf_rd_en   = 1'b1;
        rf_vs1_idx = vs1_q + {3'b000, beat_q};
        rf_vs2_idx = vs2_q + {3'b000, beat_q};
        if (beat_q != 2'd0) begin
          wrBeat      = beat_q - 2'd1;
          cycle_count = beat_q - 2'd1;
          wrActive    = !red_q;
        end
      end
      SEQ_DRAIN: begin
        cycle_count = beat_q;
        wrActive    = (nBeats_q != 3'd0);
        doneRaw     = 1'b1;
      end
      default: ;
    endcase
    rf_wr_en  = wrActive && !flush;
    done      = doneRaw && !flush;
    rf_vd_idx = 5'd0;
    rf_wr_be  = 16'h0000;
    if (wrActive && !flush) begin
      rf_vd_idx = red_q ? vd_q : (vd_q + {3'b000, wrBeat});
      rf_wr_be  = beMask;
    end
  end

  arith_wr_mask u_wr_mask (
    .vl_i        (vl_q),
    .vsew_i      (vsew_q),
    .beat_i      (wrBeat),
    .reduction_i (red_q),
    .be_o        (beMask)
  );

endmodule

// File: tb/tb_arith_sequencer.sv
// Self-checking bench for arith_sequencer: a per-cycle expectation table built
// from the op rules is compared against every DUT output on each falling edge.
module tb_arith_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_vl;
  logic [1:0]  req_vsew;
  logic        req_reduction;
  logic [4:0]  req_vs1, req_vs2, req_vd;
  logic        flush;
  logic        rf_rd_en;
  logic [4:0]  rf_vs1_idx, rf_vs2_idx;
  logic [1:0]  cycle_count;
  logic        rf_wr_en;
  logic [4:0]  rf_vd_idx;
  logic [15:0] rf_wr_be;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  arith_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_vl        (req_vl),
    .req_vsew      (req_vsew),
    .req_reduction (req_reduction),
    .req_vs1       (req_vs1),
    .req_vs2       (req_vs2),
    .req_vd        (req_vd),
    .flush         (flush),
    .rf_rd_en      (rf_rd_en),
    .rf_vs1_idx    (rf_vs1_idx),
    .rf_vs2_idx    (rf_vs2_idx),
    .cycle_count   (cycle_count),
    .rf_wr_en      (rf_wr_en),
    .rf_vd_idx     (rf_vd_idx),
    .rf_wr_be      (rf_wr_be),
    .busy          (busy),
    .done          (done)
  );

  typedef struct {
    bit rd;
    bit wr;
    bit dn;
    bit bsy;
    bit rdy;
    int v1;
    int v2;
    int vd;
    int be;
    int cc;
  } exp_t;

  localparam int MAXP = 512;
  exp_t expTab[MAXP];
  int   edgeNo = 0;
  int   checks = 0;
  int   errors = 0;
  bit   cmpOn  = 1'b0;

  // Period p is the interval that starts at the p-th rising edge.
  always @(posedge clk) edgeNo <= edgeNo + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int modelElems(input int vsew, input bit red);
    int sew = (vsew == 3) ? 2 : vsew;
    if (red) return 4;
    return 16 / (1 << sew);
  endfunction

  function automatic int modelBeats(input int vl, input int vsew, input bit red);
    int e = modelElems(vsew, red);
    int n = (vl + e - 1) / e;
    return (n > 4) ? 4 : n;
  endfunction

  function automatic int modelMask(input int vl, input int vsew, input int beat, input bit red);
    int sew  = (vsew == 3) ? 2 : vsew;
    int esz  = 1 << sew;
    int e    = modelElems(vsew, red);
    int m    = 0;
    int last = 0;
    if (red) begin
      for (int b = 0; b < esz; b++) m |= (1 << b);
      return m;
    end
    last = (vl < (beat + 1) * e) ? vl : (beat + 1) * e;
    for (int el = beat * e; el < last; el++)
      for (int b = 0; b < esz; b++) m |= (1 << ((el - beat * e) * esz + b));
    return m;
  endfunction

  function automatic void setIdle(input int p);
    if (p >= 0 && p < MAXP) begin
      expTab[p].rd  = 1'b0;
      expTab[p].wr  = 1'b0;
      expTab[p].dn  = 1'b0;
      expTab[p].bsy = 1'b0;
      expTab[p].rdy = 1'b1;
      expTab[p].v1  = 0;
      expTab[p].v2  = 0;
      expTab[p].vd  = 0;
      expTab[p].be  = 0;
      expTab[p].cc  = 0;
    end
  endfunction

  // t is the accepting edge: reads occupy periods t..t+n-1, data/writes t+1..t+n.
  function automatic void scheduleOp(input int t, input int vl, input int vsew, input bit red,
                                     input int vs1, input int vs2, input int vd);
    int n = modelBeats(vl, vsew, red);
    for (int i = t; i <= t + n; i++) begin
      expTab[i].bsy = 1'b1;
      expTab[i].rdy = 1'b0;
      expTab[i].cc  = -1;
    end
    for (int k = 0; k < n; k++) begin
      expTab[t + k].rd = 1'b1;
      expTab[t + k].v1 = (vs1 + k) % 32;
      expTab[t + k].v2 = (vs2 + k) % 32;
      expTab[t + 1 + k].cc = k;
      if (!red || k == n - 1) begin
        expTab[t + 1 + k].wr = 1'b1;
        expTab[t + 1 + k].vd = red ? vd : (vd + k) % 32;
        expTab[t + 1 + k].be = modelMask(vl, vsew, k, red);
      end
    end
    expTab[t + n].dn = 1'b1;
  endfunction

  function automatic void flushAt(input int p);
    expTab[p].wr = 1'b0;
    expTab[p].dn = 1'b0;
    for (int i = p + 1; i <= p + 12; i++) setIdle(i);
  endfunction

  function automatic void resetAt(input int p);
    for (int i = p; i <= p + 12; i++) setIdle(i);
  endfunction

  always @(negedge clk) begin
    int p;
    p = edgeNo;
    if (cmpOn && p < MAXP) begin
      checkOutput($sformatf("p%0d req_ready", p), int'(req_ready), int'(expTab[p].rdy));
      checkOutput($sformatf("p%0d busy", p), int'(busy), int'(expTab[p].bsy));
      checkOutput($sformatf("p%0d done", p), int'(done), int'(expTab[p].dn));
      checkOutput($sformatf("p%0d rf_rd_en", p), int'(rf_rd_en), int'(expTab[p].rd));
      checkOutput($sformatf("p%0d rf_wr_en", p), int'(rf_wr_en), int'(expTab[p].wr));
      if (expTab[p].rd) begin
        checkOutput($sformatf("p%0d rf_vs1_idx", p), int'(rf_vs1_idx), expTab[p].v1);
        checkOutput($sformatf("p%0d rf_vs2_idx", p), int'(rf_vs2_idx), expTab[p].v2);
      end
      if (expTab[p].wr) begin
        checkOutput($sformatf("p%0d rf_vd_idx", p), int'(rf_vd_idx), expTab[p].vd);
        checkOutput($sformatf("p%0d rf_wr_be", p), int'(rf_wr_be), expTab[p].be);
      end
      if (expTab[p].cc >= 0)
        checkOutput($sformatf("p%0d cycle_count", p), int'(cycle_count), expTab[p].cc);
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive a request for one period; it is taken at the next rising edge.
  task automatic applyStimulus(input int vl, input int vsew, input bit red, input int vs1,
                               input int vs2, input int vd, input bit withFlush);
    req_vl        = 5'(vl);
    req_vsew      = 2'(vsew);
    req_reduction = red;
    req_vs1       = 5'(vs1);
    req_vs2       = 5'(vs2);
    req_vd        = 5'(vd);
    req_valid     = 1'b1;
    flush         = withFlush;
    scheduleOp(edgeNo + 1, vl, vsew, red, vs1, vs2, vd);
    nextCycle();
    req_valid = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_vl        = 5'd0;
    req_vsew      = 2'd0;
    req_reduction = 1'b0;
    req_vs1       = 5'd0;
    req_vs2       = 5'd0;
    req_vd        = 5'd0;
    flush         = 1'b0;
    for (int i = 0; i < MAXP; i++) setIdle(i);

    checkOutput("pin beats vl16 sew0", modelBeats(16, 0, 1'b0), 1);
    checkOutput("pin be vl16 sew0 b0", modelMask(16, 0, 0, 1'b0), 16'hFFFF);
    checkOutput("pin beats vl10 sew2", modelBeats(10, 2, 1'b0), 3);
    checkOutput("pin be vl10 sew2 b1", modelMask(10, 2, 1, 1'b0), 16'hFFFF);
    checkOutput("pin be vl10 sew2 b2", modelMask(10, 2, 2, 1'b0), 16'h00FF);
    checkOutput("pin beats red vl7", modelBeats(7, 1, 1'b1), 2);
    checkOutput("pin be red sew1", modelMask(7, 1, 1, 1'b1), 16'h0003);
    checkOutput("pin beats vl0", modelBeats(0, 1, 1'b0), 0);
    checkOutput("pin beats vl31 sew2", modelBeats(31, 2, 1'b0), 4);
    checkOutput("pin be vl31 sew2 b3", modelMask(31, 2, 3, 1'b0), 16'hFFFF);
    checkOutput("pin be vl5 sew3 b1", modelMask(5, 3, 1, 1'b0), 16'h000F);

    repeat (3) @(posedge clk);
    #1;
    cmpOn = 1'b1;
    nextCycle();
    reset = 1'b0;
    nextCycle();

    applyStimulus(16, 0, 1'b0, 1, 2, 4, 1'b0);
    repeat (2) nextCycle();
    applyStimulus(10, 2, 1'b0, 3, 8, 12, 1'b0);
    repeat (4) nextCycle();
    applyStimulus(7, 1, 1'b1, 5, 6, 20, 1'b0);
    repeat (3) nextCycle();
    // flush alongside an IDLE request must not block the accept
    applyStimulus(0, 1, 1'b0, 7, 7, 9, 1'b1);
    repeat (1) nextCycle();
    applyStimulus(31, 2, 1'b0, 28, 29, 30, 1'b0);
    repeat (5) nextCycle();
    applyStimulus(5, 3, 1'b0, 1, 1, 2, 1'b0);
    repeat (3) nextCycle();

    applyStimulus(31, 1, 1'b0, 10, 11, 16, 1'b0);
    repeat (2) nextCycle();
    flush = 1'b1;
    flushAt(edgeNo);
    nextCycle();
    flush = 1'b0;
    applyStimulus(3, 0, 1'b0, 2, 3, 4, 1'b0);
    repeat (2) nextCycle();

    applyStimulus(20, 2, 1'b0, 1, 2, 3, 1'b0);
    nextCycle();
    reset = 1'b1;
    resetAt(edgeNo);
    repeat (2) nextCycle();
    reset = 1'b0;
    nextCycle();
    applyStimulus(8, 2, 1'b1, 4, 5, 6, 1'b0);
    repeat (4) nextCycle();

    cmpOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
